// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: captures execute results for the memory stage,
// inserts load-use bubbles, freezes on memory stalls and drains after HALT.
module ex_mem_pipe_reg #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_stall,
    input  logic          exex_stall,
    input  logic          valid_ex,
    input  logic [DW-1:0] instr_ex,
    input  logic [DW-1:0] pc2_ex,
    input  logic [DW-1:0] ALUOut_ex,
    input  logic [DW-1:0] WriteData_ex,
    input  logic [1:0]    RegDst_ex,
    input  logic          RegWrite_ex,
    input  logic          DMemEn_ex,
    input  logic          DMemWrite_ex,
    input  logic          MemtoReg_ex,
    input  logic          Halt_ex,
    output logic          valid_exmem,
    output logic [DW-1:0] instr_exmem,
    output logic [DW-1:0] pc2_exmem,
    output logic [DW-1:0] ALUOut_exmem,
    output logic [DW-1:0] WriteData_exmem,
    output logic [1:0]    RegDst_exmem,
    output logic          RegWrite_exmem,
    output logic          DMemEn_exmem,
    output logic          DMemWrite_exmem,
    output logic          MemtoReg_exmem,
    output logic          Halt_exmem,
    output logic          hold_upstream,
    output logic          halted,
    output logic [CW-1:0] bubble_cnt
);

    localparam logic [DW-1:0] NOP = DW'(16'h0800);

    logic          valid_reg;
    logic [DW-1:0] instr_reg;
    logic [DW-1:0] pc2_reg;
    logic [DW-1:0] alu_out_reg;
    logic [DW-1:0] write_data_reg;
    logic [1:0]    reg_dst_reg;
    logic          reg_write_reg;
    logic          dmem_en_reg;
    logic          dmem_write_reg;
    logic          mem_to_reg_reg;
    logic          halt_reg;
    logic          halted_reg;
    logic [CW-1:0] bubble_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg      <= 1'b0;
            instr_reg      <= NOP;
            pc2_reg        <= '0;
            alu_out_reg    <= '0;
            write_data_reg <= '0;
            reg_dst_reg    <= 2'b00;
            reg_write_reg  <= 1'b0;
            dmem_en_reg    <= 1'b0;
            dmem_write_reg <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            halt_reg       <= 1'b0;
            halted_reg     <= 1'b0;
            bubble_cnt_reg <= '0;
        end else if (mem_stall) begin
            // Frozen: every register, including the bubble counter, holds.
        end else if (halted_reg || exex_stall) begin
            valid_reg      <= 1'b0;
            instr_reg      <= NOP;
            pc2_reg        <= '0;
            alu_out_reg    <= '0;
            write_data_reg <= '0;
            reg_dst_reg    <= 2'b00;
            reg_write_reg  <= 1'b0;
            dmem_en_reg    <= 1'b0;
            dmem_write_reg <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            halt_reg       <= 1'b0;
            // Drain bubbles after HALT are not load-use bubbles, so only count the latter.
            if (!halted_reg && (bubble_cnt_reg != '1))
                bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
        end else begin
            valid_reg      <= valid_ex;
            instr_reg      <= instr_ex;
            pc2_reg        <= pc2_ex;
            alu_out_reg    <= ALUOut_ex;
            write_data_reg <= WriteData_ex;
            reg_dst_reg    <= RegDst_ex;
            reg_write_reg  <= valid_ex & RegWrite_ex;
            dmem_en_reg    <= valid_ex & DMemEn_ex;
            // A write strobe without its enable would confuse the memory, so drop it.
            dmem_write_reg <= valid_ex & DMemEn_ex & DMemWrite_ex;
            mem_to_reg_reg <= valid_ex & MemtoReg_ex;
            halt_reg       <= valid_ex & Halt_ex;
            if (valid_ex && Halt_ex)
                halted_reg <= 1'b1;
        end
    end

    assign hold_upstream   = mem_stall | exex_stall;
    assign valid_exmem     = valid_reg;
    assign instr_exmem     = instr_reg;
    assign pc2_exmem       = pc2_reg;
    assign ALUOut_exmem    = alu_out_reg;
    assign WriteData_exmem = write_data_reg;
    assign RegDst_exmem    = reg_dst_reg;
    assign RegWrite_exmem  = reg_write_reg;
    assign DMemEn_exmem    = dmem_en_reg;
    assign DMemWrite_exmem = dmem_write_reg;
    assign MemtoReg_exmem  = mem_to_reg_reg;
    assign Halt_exmem      = halt_reg;
    assign halted          = halted_reg;
    assign bubble_cnt      = bubble_cnt_reg;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: vector table for captures plus
// hand-written stall, drain, saturation and reset sequences.
module tb_ex_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_stall, exex_stall, valid_ex;
    logic [15:0] instr_ex, pc2_ex, ALUOut_ex, WriteData_ex;
    logic [1:0]  RegDst_ex;
    logic        RegWrite_ex, DMemEn_ex, DMemWrite_ex, MemtoReg_ex, Halt_ex;

    logic        valid_exmem;
    logic [15:0] instr_exmem, pc2_exmem, ALUOut_exmem, WriteData_exmem;
    logic [1:0]  RegDst_exmem;
    logic        RegWrite_exmem, DMemEn_exmem, DMemWrite_exmem, MemtoReg_exmem, Halt_exmem;
    logic        hold_upstream, halted;
    logic [15:0] bubble_cnt;

    logic        s_valid;
    logic [15:0] s_instr, s_pc2, s_alu, s_wd;
    logic [1:0]  s_rd;
    logic        s_rw, s_den, s_dwr, s_m2r, s_halt, s_hold, s_halted;
    logic [3:0]  s_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(.DW(16), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall), .exex_stall(exex_stall),
        .valid_ex(valid_ex), .instr_ex(instr_ex), .pc2_ex(pc2_ex), .ALUOut_ex(ALUOut_ex),
        .WriteData_ex(WriteData_ex), .RegDst_ex(RegDst_ex), .RegWrite_ex(RegWrite_ex),
        .DMemEn_ex(DMemEn_ex), .DMemWrite_ex(DMemWrite_ex), .MemtoReg_ex(MemtoReg_ex),
        .Halt_ex(Halt_ex), .valid_exmem(valid_exmem), .instr_exmem(instr_exmem),
        .pc2_exmem(pc2_exmem), .ALUOut_exmem(ALUOut_exmem), .WriteData_exmem(WriteData_exmem),
        .RegDst_exmem(RegDst_exmem), .RegWrite_exmem(RegWrite_exmem),
        .DMemEn_exmem(DMemEn_exmem), .DMemWrite_exmem(DMemWrite_exmem),
        .MemtoReg_exmem(MemtoReg_exmem), .Halt_exmem(Halt_exmem),
        .hold_upstream(hold_upstream), .halted(halted), .bubble_cnt(bubble_cnt)
    );

    ex_mem_pipe_reg #(.DW(16), .CW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall), .exex_stall(exex_stall),
        .valid_ex(valid_ex), .instr_ex(instr_ex), .pc2_ex(pc2_ex), .ALUOut_ex(ALUOut_ex),
        .WriteData_ex(WriteData_ex), .RegDst_ex(RegDst_ex), .RegWrite_ex(RegWrite_ex),
        .DMemEn_ex(DMemEn_ex), .DMemWrite_ex(DMemWrite_ex), .MemtoReg_ex(MemtoReg_ex),
        .Halt_ex(Halt_ex), .valid_exmem(s_valid), .instr_exmem(s_instr),
        .pc2_exmem(s_pc2), .ALUOut_exmem(s_alu), .WriteData_exmem(s_wd),
        .RegDst_exmem(s_rd), .RegWrite_exmem(s_rw), .DMemEn_exmem(s_den),
        .DMemWrite_exmem(s_dwr), .MemtoReg_exmem(s_m2r), .Halt_exmem(s_halt),
        .hold_upstream(s_hold), .halted(s_halted), .bubble_cnt(s_cnt)
    );

    typedef struct {
        logic        v;
        logic [15:0] instr, pc2, alu, wd;
        logic [1:0]  rd;
        logic        rw, den, dwr, m2r;
        logic        e_v, e_rw, e_den, e_dwr, e_m2r;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc2,
                         input logic [15:0] alu, input logic [15:0] wd, input logic [1:0] rd,
                         input logic rw, input logic den, input logic dwr, input logic m2r,
                         input logic hlt);
        valid_ex = v; instr_ex = instr; pc2_ex = pc2; ALUOut_ex = alu; WriteData_ex = wd;
        RegDst_ex = rd; RegWrite_ex = rw; DMemEn_ex = den; DMemWrite_ex = dwr;
        MemtoReg_ex = m2r; Halt_ex = hlt;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, valid_exmem, 0);
        check({tag, "_instr"}, instr_exmem, 16'h0800);
        check({tag, "_alu"}, ALUOut_exmem, 0);
        check({tag, "_wd"}, WriteData_exmem, 0);
        check({tag, "_pc2"}, pc2_exmem, 0);
        check({tag, "_rd"}, RegDst_exmem, 0);
        check({tag, "_ctrl"}, {RegWrite_exmem, DMemEn_exmem, DMemWrite_exmem, MemtoReg_exmem, Halt_exmem}, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_cnt"}, bubble_cnt, 0);
        check({tag, "_sat_cnt"}, s_cnt, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h4123, 16'h0002, 16'h1234, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h8A41, 16'h0004, 16'h0040, 16'h0000, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1,
                    1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 16'h9B42, 16'h0006, 16'h0080, 16'hBEEF, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h9C43, 16'h0008, 16'h0090, 16'hCAFE, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h8D44, 16'h000A, 16'h5555, 16'hAAAA, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h4E45, 16'h000C, 16'hFFFF, 16'h0001, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset with random inputs
        rst_n = 1'b0; mem_stall = 1'b0; exex_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            exex_stall = 1'($urandom);
            tick();
        end
        check_reset_state("in_reset");
        drive(0, 16'h0800, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exex_stall = 1'b0;
        rst_n = 1'b1;
        #1;
        check_reset_state("after_release");
        $display("reset: released, outputs at reset values");

        for (int i = 0; i < 4; i++) begin
            mem_stall = i[0]; exex_stall = i[1];
            #1;
            check("hold_upstream_comb", hold_upstream, i[0] | i[1]);
        end
        mem_stall = 1'b0; exex_stall = 1'b0;

        // Table-driven captures
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].v, vecs[i].instr, vecs[i].pc2, vecs[i].alu, vecs[i].wd, vecs[i].rd,
                  vecs[i].rw, vecs[i].den, vecs[i].dwr, vecs[i].m2r, 1'b0);
            tick();
            $display("vec %0d: valid=%0b alu=%h rw=%0b den=%0b dwr=%0b m2r=%0b", i, valid_exmem,
                     ALUOut_exmem, RegWrite_exmem, DMemEn_exmem, DMemWrite_exmem, MemtoReg_exmem);
            check("vec_valid", valid_exmem, vecs[i].e_v);
            check("vec_ctrl", {RegWrite_exmem, DMemEn_exmem, DMemWrite_exmem, MemtoReg_exmem, Halt_exmem},
                  {vecs[i].e_rw, vecs[i].e_den, vecs[i].e_dwr, vecs[i].e_m2r, 1'b0});
            check("vec_alu", ALUOut_exmem, vecs[i].alu);
            check("vec_wd", WriteData_exmem, vecs[i].wd);
            check("vec_pc2", pc2_exmem, vecs[i].pc2);
            if (vecs[i].v) begin
                check("vec_instr", instr_exmem, vecs[i].instr);
                check("vec_rd", RegDst_exmem, vecs[i].rd);
            end
            check("vec_cnt", bubble_cnt, 0);
        end

        // Load-use: capture a load, then one stall cycle
        drive(1, 16'h8A41, 16'h0010, 16'h0044, 0, 2'd1, 1, 1, 0, 1, 0);
        tick();
        check("lu_load_den", DMemEn_exmem, 1);
        drive(1, 16'h4111, 16'h0012, 16'h7777, 0, 2'd2, 1, 0, 0, 0, 0);
        exex_stall = 1'b1;
        #1;
        check("lu_hold_upstream", hold_upstream, 1);
        tick();
        $display("load-use: bubble instr=%h cnt=%0d", instr_exmem, bubble_cnt);
        check("lu_valid", valid_exmem, 0);
        check("lu_rw", RegWrite_exmem, 0);
        check("lu_den", DMemEn_exmem, 0);
        check("lu_instr", instr_exmem, 16'h0800);
        check("lu_rd", RegDst_exmem, 0);
        check("lu_cnt", bubble_cnt, 1);
        tick();
        tick();
        check("lu_consecutive_cnt", bubble_cnt, 3);
        exex_stall = 1'b0;
        tick();
        check("lu_resume_alu", ALUOut_exmem, 16'h7777);
        check("lu_resume_valid", valid_exmem, 1);

        // Memory stall over load-use
        drive(1, 16'h4222, 16'h0014, 16'hABCD, 0, 2'd1, 1, 0, 0, 0, 0);
        tick();
        drive(1, 16'h4333, 16'h0016, 16'h1111, 0, 2'd2, 1, 0, 0, 0, 0);
        mem_stall = 1'b1; exex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("mem stall cycle %0d: alu=%h cnt=%0d", i, ALUOut_exmem, bubble_cnt);
            check("ms_alu", ALUOut_exmem, 16'hABCD);
            check("ms_valid", valid_exmem, 1);
            check("ms_cnt", bubble_cnt, 3);
        end
        mem_stall = 1'b0;
        tick();
        check("ms_release_valid", valid_exmem, 0);
        check("ms_release_alu", ALUOut_exmem, 0);
        check("ms_release_cnt", bubble_cnt, 4);
        check("ms_release_sat_cnt", s_cnt, 4);

        // Saturation on the narrow counter
        for (int i = 0; i < 20; i++) begin
            tick();
            check("sat_cnt4", s_cnt, (5 + i > 15) ? 15 : 5 + i);
            check("sat_cnt16", bubble_cnt, 5 + i);
        end
        $display("saturation: cnt4=%h cnt16=%0d", s_cnt, bubble_cnt);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_sat_cnt4", s_cnt, 0);
        check("rst_mid_cnt16", bubble_cnt, 0);
        check("rst_mid_instr", instr_exmem, 16'h0800);
        exex_stall = 1'b0;
        tick();
        rst_n = 1'b1;

        // HALT capture and drain
        drive(1, 16'h0000, 16'h0020, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check("halt_flag", Halt_exmem, 1);
        check("halt_sticky", halted, 1);
        check("halt_valid", valid_exmem, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h4100 + 16'(i), 16'h0022, 16'h3000 + 16'(i), 0, 2'd2, 1, 0, 0, 0, 0);
            exex_stall = (i == 1);
            tick();
            $display("drain %0d: valid=%0b rw=%0b cnt=%0d", i, valid_exmem, RegWrite_exmem, bubble_cnt);
            check("drain_valid", valid_exmem, 0);
            check("drain_rw", RegWrite_exmem, 0);
            check("drain_halt", Halt_exmem, 0);
            check("drain_cnt", bubble_cnt, 0);
            check("drain_halted", halted, 1);
        end
        exex_stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_drain_halted", halted, 0);
        check("rst_mid_drain_valid", valid_exmem, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- EX/MEM pipeline register between the execute stage and the data-memory stage.
- Captures EX results and control each cycle and feeds the MEM stage and the forwarding unit (RegDst_exmem, instr_exmem, DMemEn_exmem, RegWrite_exmem).
- Inserts a bubble when the forwarding unit raises exex_stall (load-use), freezes on a data-memory stall, and drains after a HALT.
- Keeps a saturating bubble counter for performance debug.

Parameters:
- DW, 16, datapath width (ALU result, store data, PC+2, instruction).
- CW, 16, width of the bubble performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_stall  in  1  data memory busy; freeze this register.
- exex_stall  in  1  load-use stall from the forwarding unit.
- valid_ex  in  1  EX stage holds a real instruction.
- instr_ex  in  DW  instruction in EX.
- pc2_ex  in  DW  PC+2 of the EX instruction.
- ALUOut_ex  in  DW  ALU result.
- WriteData_ex  in  DW  store data (already forwarded).
- RegDst_ex  in  2  write-register select code.
- RegWrite_ex, DMemEn_ex, DMemWrite_ex, MemtoReg_ex, Halt_ex  in  1 each  control bits.
- valid_exmem  out  1  registered valid.
- instr_exmem, pc2_exmem, ALUOut_exmem, WriteData_exmem  out  DW each  registered copies.
- RegDst_exmem  out  2  registered RegDst.
- RegWrite_exmem, DMemEn_exmem, DMemWrite_exmem, MemtoReg_exmem, Halt_exmem  out  1 each  registered controls.
- hold_upstream  out  1  combinational: mem_stall OR exex_stall; ID/EX and earlier stages hold.
- halted  out  1  sticky: a valid HALT has been captured.
- bubble_cnt  out  CW  number of bubbles inserted, saturating.

Behaviour:
- Reset (rst_n low, asynchronous), all outputs:
  - valid, controls, ALUOut, WriteData, pc2, RegDst, halted, bubble_cnt = 0.
  - instr_exmem = 16'h0800 (NOP).
- Priority per rising edge: mem_stall > halted > exex_stall > capture.
- Hold (mem_stall=1): every register keeps its value. bubble_cnt does not count. exex_stall is ignored.
- Drain (halted=1, mem_stall=0): load a bubble every cycle. bubble_cnt does not count.
- Bubble (exex_stall=1, mem_stall=0, halted=0):
  - valid, RegWrite, DMemEn, DMemWrite, MemtoReg, Halt = 0.
  - instr = NOP, RegDst = 0.
  - Data fields are don't-care and are loaded with 0.
  - bubble_cnt increments and saturates at all-ones.
- Capture (none of the above): all _ex inputs are loaded.
  - If valid_ex=0, the controls are forced to bubble values but data is still loaded; bubble_cnt does not count.
- halted: set on a capture where valid_ex=1 and Halt_ex=1. Cleared only by reset.
  - The cycle halted is set, the HALT instruction itself sits in the register with Halt_exmem=1.
- Latency: one cycle from EX inputs to _exmem outputs.
- hold_upstream: purely combinational, no registered delay.
- Stall interactions:
  - A load-use stall resolves itself: after the bubble, DMemEn_exmem=0, so the forwarding unit deasserts exex_stall next cycle.
  - exex_stall asserted on consecutive cycles inserts one bubble per cycle.
- Reset mid-stall or mid-drain: the asynchronous reset wins immediately; state returns to reset values.
- Store gating: DMemWrite_exmem=1 only if DMemEn_exmem=1. If DMemWrite_ex=1 with DMemEn_ex=0, the register stores DMemWrite=0.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release → all outputs 0, instr_exmem=16'h0800, hold_upstream follows its inputs combinationally.
- Normal flow: valid_ex=1, ALUOut_ex=16'h1234, RegWrite_ex=1, RegDst_ex=2 → next edge ALUOut_exmem=16'h1234, RegWrite_exmem=1, RegDst_exmem=2, valid_exmem=1.
- Load-use: capture a load (DMemEn=1, MemtoReg=1), then pulse exex_stall=1 for one cycle → next edge RegWrite_exmem=0, DMemEn_exmem=0, instr_exmem=16'h0800, bubble_cnt=1, hold_upstream=1 during the stall.
- Mem stall over load-use: mem_stall=1 and exex_stall=1 for 3 cycles → outputs unchanged, bubble_cnt unchanged. Release mem_stall → one bubble, bubble_cnt+1.
- Halt drain: capture valid HALT (Halt_ex=1) → Halt_exmem=1, halted=1. Next 4 edges with valid instructions presented → valid_exmem=0, RegWrite_exmem=0, bubble_cnt unchanged.
- Saturation: CW=4, 20 consecutive exex_stall cycles → bubble_cnt stops at 4'hF. Assert rst_n=0 mid-sequence → bubble_cnt=0 immediately.
